// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler
// Shares one AXI-Stream TX port between forwarded echo frames and a periodic
// three-byte heartbeat frame. Ownership changes only between frames (IDLE).
//
// Optional feature macro: UDP_TX_SCHEDULER_HEARTBEAT_EN
//   defined   : heartbeat timer, HB0-HB2 frame states, hb_sent/hb_dropped counters.
//   undefined : pure echo pass-through framed by IDLE/ECHO. hb_enable and
//               hb_interval are ignored, and both counters read as zero.
//
// Reset is synchronous and active-low on rst.
// A frame cut short by reset is never closed with tlast, and the sink discards it.

module udp_tx_scheduler #(
  parameter int                    DATA_WIDTH = 8,      // only 8 is supported
  parameter logic [DATA_WIDTH-1:0] HB_BYTE0   = 8'h61,  // "a"
  parameter logic [DATA_WIDTH-1:0] HB_BYTE1   = 8'h62,  // "b"
  parameter logic [DATA_WIDTH-1:0] HB_BYTE2   = 8'h63   // "c"
) (
  input  logic                  clk,
  input  logic                  rst,

  // Echo-frame input stream
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic                  s_tuser,

  // Payload TX output stream
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tuser,

  // Heartbeat control and status
  input  logic                  hb_enable,
  input  logic [31:0]           hb_interval,
  output logic [1:0]            grant,
  output logic [15:0]           hb_sent,
  output logic [15:0]           hb_dropped
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ECHO = 3'd1,
    S_HB0  = 3'd2,
    S_HB1  = 3'd3,
    S_HB2  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic   w_take_echo;  // IDLE hands the port to the echo source this cycle
  logic   w_take_hb;    // IDLE hands the port to the heartbeat this cycle
  logic   w_hb_req;     // a heartbeat frame is waiting
  logic   w_prio_hb;    // heartbeat wins the next tie

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is written with non-blocking assignments only.
    // Every flop then samples pre-edge values, and the result does not
    // depend on the order in which blocks are evaluated.
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // IDLE arbitration, frame sequencing and per-state output muxing.
  always_comb begin
    // NOTE: every signal driven here gets a default before the case.
    // A path that skips an assignment would otherwise infer a latch.
    w_state_nxt = r_state;
    w_take_echo = 1'b0;
    w_take_hb   = 1'b0;
    grant       = 2'b00;
    s_tready    = 1'b0;
    m_tdata     = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tuser     = 1'b0;

    case (r_state)
      S_IDLE: begin
        // On a tie, serve whichever source was not served last.
        if (s_tvalid && w_hb_req) begin
          w_take_hb   = w_prio_hb;
          w_take_echo = !w_prio_hb;
        end else begin
          w_take_echo = s_tvalid;
          w_take_hb   = w_hb_req;
        end
        if (w_take_echo) begin
          w_state_nxt = S_ECHO;
        end else if (w_take_hb) begin
          w_state_nxt = S_HB0;
        end
      end

      S_ECHO: begin
        // Combinational pass-through. The frame ends when its last beat is accepted.
        grant    = 2'b01;
        m_tdata  = s_tdata;
        m_tvalid = s_tvalid;
        m_tlast  = s_tlast;
        m_tuser  = s_tuser;
        s_tready = m_tready;
        if (s_tvalid && m_tready && s_tlast) begin
          w_state_nxt = S_IDLE;
        end
      end

      // Heartbeat beats are constant per state, so they stay stable under backpressure.
      S_HB0: begin
        grant    = 2'b10;
        m_tvalid = 1'b1;
        m_tdata  = HB_BYTE0;
        if (m_tready) w_state_nxt = S_HB1;
      end

      S_HB1: begin
        grant    = 2'b10;
        m_tvalid = 1'b1;
        m_tdata  = HB_BYTE1;
        if (m_tready) w_state_nxt = S_HB2;
      end

      S_HB2: begin
        grant    = 2'b10;
        m_tvalid = 1'b1;
        m_tdata  = HB_BYTE2;
        m_tlast  = 1'b1;
        if (m_tready) w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef UDP_TX_SCHEDULER_HEARTBEAT_EN

  logic [31:0] r_hb_timer;
  logic        r_hb_pending;
  logic        r_prio_hb;
  logic [15:0] r_hb_sent;
  logic [15:0] r_hb_dropped;
  logic        w_hb_expire;
  logic        w_hb_done;

  // The timer runs only when enabled with a non-zero period.
  // The expiry fires on the last count of each period.
  assign w_hb_expire = hb_enable && (hb_interval != 32'd0) &&
                       (r_hb_timer >= (hb_interval - 32'd1));
  assign w_hb_done   = (r_state == S_HB2) && m_tready;

  assign w_hb_req    = r_hb_pending;
  assign w_prio_hb   = r_prio_hb;
  assign hb_sent     = r_hb_sent;
  assign hb_dropped  = r_hb_dropped;

  // Heartbeat period timer. Disabling it rewinds the count to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hb_timer <= '0;
    end else if (!hb_enable || w_hb_expire) begin
      r_hb_timer <= '0;
    end else if (hb_interval != 32'd0) begin
      r_hb_timer <= r_hb_timer + 32'd1;
    end
  end

  // Pending flag, round-robin pointer and frame counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hb_pending <= 1'b0;
      r_prio_hb    <= 1'b0;
      r_hb_sent    <= '0;
      r_hb_dropped <= '0;
    end else begin
      // An expiry in the same cycle as the HB0 grant re-arms the flag.
      if (w_hb_expire) begin
        r_hb_pending <= 1'b1;
      end else if (w_take_hb) begin
        r_hb_pending <= 1'b0;
      end

      // An expiry is lost only if the earlier request is still waiting.
      // If that request is consumed in this same cycle, the expiry is kept.
      if (w_hb_expire && r_hb_pending && !w_take_hb) begin
        r_hb_dropped <= r_hb_dropped + 16'd1;
      end

      if (w_hb_done) begin
        r_hb_sent <= r_hb_sent + 16'd1;
      end

      // Whichever source is served now loses the next tie.
      if (w_take_echo) begin
        r_prio_hb <= 1'b1;
      end else if (w_take_hb) begin
        r_prio_hb <= 1'b0;
      end
    end
  end

`else

  // The heartbeat never requests, so HB0-HB2 are unreachable and get trimmed.
  logic w_unused_hb;

  assign w_hb_req    = 1'b0;
  assign w_prio_hb   = 1'b0;
  assign hb_sent     = '0;
  assign hb_dropped  = '0;
  assign w_unused_hb = ^{hb_enable, hb_interval, w_take_hb};

`endif

endmodule
